// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with request FSM and instruction FIFO
//
// Purpose:
//   Issues word-aligned fetches to instruction memory (one outstanding at a
//   time), buffers returned words with their fetch address in a small FIFO and
//   presents the head entry to the core. Redirects flush the buffer and drop
//   any in-flight response.
//
// Optional feature (macro FETCH_BYPASS_EN):
//   When defined, a response arriving while the buffer is empty is presented
//   on the instruction outputs in the same cycle; if the core takes it that
//   cycle it is never written into the buffer. When undefined, all
//   instruction outputs come from registered buffer state.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   redirect_valid    fetch from redirect_target (branch / JAL / JALR)
//   redirect_target   new fetch address, bits [1:0] ignored
//   instruction_ready core consumes the head instruction this cycle
//   instruction_valid head entry valid
//   instruction       head instruction word
//   instruction_pc    address the head instruction was fetched from
//   imem_request      fetch request outstanding
//   imem_address      word-aligned fetch address, stable until imem_ack
//   imem_ack          memory returns imem_data for the outstanding request
//   imem_data         fetched word, valid with imem_ack

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUFFER_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        instruction_ready,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ack,
    input  logic [31:0] imem_data
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        buf_instr_q [BUFFER_DEPTH];
    logic [31:0]        buf_instr_d [BUFFER_DEPTH];
    logic [31:0]        buf_pc_q    [BUFFER_DEPTH];
    logic [31:0]        buf_pc_d    [BUFFER_DEPTH];

    logic               buf_valid;
    logic [31:0]        head_instr;
    logic [31:0]        head_pc;
    logic               ack_in_wait;
    logic               bypass;
    logic               pop;
    logic               buf_pop;
    logic               push;
    logic [CNT_W-1:0]   count_after;
    logic [31:0]        target_aligned;
    logic [31:0]        next_pc;

    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    assign next_pc        = fetch_pc_q + 32'd4;

    // Head of buffer; forced to zero when empty so stale entries never leak out.
    assign buf_valid  = (count_q != '0);
    assign head_instr = buf_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign head_pc    = buf_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;

    // A response only counts when it belongs to a live (non-discarded) request.
    assign ack_in_wait = (state_q == ST_WAIT) && imem_ack && !reset;

`ifdef FETCH_BYPASS_EN
    assign bypass = ack_in_wait && !redirect_valid && !buf_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instruction_valid = buf_valid | bypass;
    assign instruction       = bypass ? imem_data  : head_instr;
    assign instruction_pc    = bypass ? fetch_pc_q : head_pc;

    assign imem_request = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
    assign imem_address = addr_q;

    // Redirect overrides any pop. A bypassed word taken by the core is consumed
    // directly and never occupies a buffer slot.
    assign pop     = instruction_valid && instruction_ready && !redirect_valid;
    assign buf_pop = pop && buf_valid;
    assign push    = ack_in_wait && !redirect_valid && !(bypass && instruction_ready);

    assign count_after = count_q + CNT_W'(push) - CNT_W'(buf_pop);

    // Request state machine and fetch address tracking.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = target_aligned;
                end else if (count_q < DEPTH_C) begin
                    state_d = ST_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = target_aligned;
                    state_d    = imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_d = next_pc;
                    // Issue back-to-back only while there is room after this cycle.
                    if (count_after < DEPTH_C) begin
                        addr_d = next_pc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                // imem_address keeps the old request until its ack drains it.
                if (redirect_valid) begin
                    fetch_pc_d = target_aligned;
                end
                if (imem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction buffer bookkeeping.
    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_data;
                buf_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (buf_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Buffer storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

endmodule
